// File: rtl/vga_pattern_sequencer_if.sv
// Coordinate and colour bus between the VGA controller and the pattern sequencer.
// The controller (master) drives coordinates and controls; the sequencer (slave) returns RGB.
interface vga_pattern_sequencer_if;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 10;
    localparam int unsigned ID_W    = 2;

    logic               auto;
    logic [ID_W-1:0]    mode_sel;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic [ID_W-1:0]    pattern_id;
    logic               frame_tick;

    modport master (
        output auto, mode_sel, pixel_x, pixel_y,
        input  red, green, blue, pattern_id, frame_tick
    );

    modport slave (
        input  auto, mode_sel, pixel_x, pixel_y,
        output red, green, blue, pattern_id, frame_tick
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern generator for the VGA colour path.
// Pattern changes only at frame start, so a switch can never tear the picture.
module vga_pattern_sequencer #(
    parameter int unsigned FRAMES_PER_PATTERN = 60,
    parameter int unsigned H_LAST             = 639,
    parameter int unsigned V_LAST             = 479
) (
    input  logic                   clock,
    input  logic                   resetn,
    vga_pattern_sequencer_if.slave bus
);
    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 10;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        BARS     = 2'd0,
        CHECKER  = 2'd1,
        GRADIENT = 2'd2,
        BORDER   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [COORD_W-1:0]   prev_y_q;
    logic                 frame_tick_q;
    logic [COLOR_W-1:0]   red_q, green_q, blue_q;
    logic [COLOR_W-1:0]   red_c, green_c, blue_c;
    logic                 frame_start_c;
    logic                 checker_c;
    logic                 on_border_c;

    assign frame_start_c = (bus.pixel_y == '0) && (prev_y_q != '0);

    // State register, frame detection and registered colour.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= BARS;
            count_q      <= '0;
            prev_y_q     <= '0;
            frame_tick_q <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prev_y_q     <= bus.pixel_y;
            frame_tick_q <= frame_start_c;
            red_q        <= red_c;
            green_q      <= green_c;
            blue_q       <= blue_c;
        end
    end

    // Next pattern; auto/manual choice is sampled only at frame start.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (frame_start_c) begin
            if (bus.auto) begin
                if (count_q == CNT_W'(FRAMES_PER_PATTERN - 1)) begin
                    count_d = '0;
                    state_d = state_t'(state_q + 2'd1);
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                count_d = '0;
                state_d = state_t'(bus.mode_sel);
            end
        end
    end

    assign checker_c   = bus.pixel_x[5] ^ bus.pixel_y[5];
    assign on_border_c = (bus.pixel_x == '0) || (bus.pixel_x == COORD_W'(H_LAST)) ||
                         (bus.pixel_y == '0) || (bus.pixel_y == COORD_W'(V_LAST));

    // Pattern equations for the current pixel.
    always_comb begin
        red_c   = '0;
        green_c = '0;
        blue_c  = '0;
        case (state_q)
            BARS: begin
                red_c   = {COLOR_W{~bus.pixel_x[8]}};
                green_c = {COLOR_W{~bus.pixel_x[7]}};
                blue_c  = {COLOR_W{~bus.pixel_x[6]}};
            end
            CHECKER: begin
                red_c   = {COLOR_W{checker_c}};
                green_c = {COLOR_W{checker_c}};
                blue_c  = {COLOR_W{checker_c}};
            end
            GRADIENT: begin
                red_c   = bus.pixel_x;
                green_c = {bus.pixel_y[8:0], 1'b0};
            end
            BORDER: begin
                red_c   = {COLOR_W{on_border_c}};
                green_c = {COLOR_W{on_border_c}};
                blue_c  = {COLOR_W{on_border_c}};
            end
            default: ;
        endcase
    end

    assign bus.red        = red_q;
    assign bus.green      = green_q;
    assign bus.blue       = blue_q;
    assign bus.pattern_id = state_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer with a 3-frame auto period.
// Expected colours come from the pattern equations evaluated by hand.
module tb_vga_pattern_sequencer;
    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    vga_pattern_sequencer_if bus ();

    vga_pattern_sequencer #(
        .FRAMES_PER_PATTERN(3),
        .H_LAST            (639),
        .V_LAST            (479)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one pixel; return 1 ns after the edge that registers it.
    task automatic step(input logic [9:0] x, input logic [9:0] y);
        @(negedge clock);
        bus.pixel_x = x;
        bus.pixel_y = y;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn      = 1'b0;
        bus.pixel_x = '0;
        bus.pixel_y = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic frame_wrap();
        step(10'd10, 10'd479);
        step(10'd10, 10'd0);
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetn       = 1'b0;
        bus.auto     = 1'b0;
        bus.mode_sel = 2'd0;
        bus.pixel_x  = 10'd100;
        bus.pixel_y  = 10'd10;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.red !== 10'h000) begin errors++; $display("FAIL reset_red got %h expected 000", bus.red); end
        checks++; if (bus.pattern_id !== 2'd0) begin errors++; $display("FAIL reset_pid got %0d expected 0", bus.pattern_id); end
        checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b expected 0", bus.frame_tick); end
        @(negedge clock);
        bus.pixel_y = '0;
        resetn = 1'b1;
        step(10'd0, 10'd0);
        checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_no_tick got %b expected 0", bus.frame_tick); end
    endtask

    task automatic test_bars();
        step(10'd100, 10'd10);
        checks++; if ({bus.red, bus.green, bus.blue} !== {10'h3FF, 10'h3FF, 10'h000})
            begin errors++; $display("FAIL bars_x100 got %h/%h/%h expected 3ff/3ff/000", bus.red, bus.green, bus.blue); end
        checks++; if (bus.pattern_id !== 2'd0) begin errors++; $display("FAIL bars_pid got %0d expected 0", bus.pattern_id); end
        step(10'd200, 10'd10);
        checks++; if ({bus.red, bus.green, bus.blue} !== {10'h3FF, 10'h000, 10'h000})
            begin errors++; $display("FAIL bars_x200 got %h/%h/%h expected 3ff/000/000", bus.red, bus.green, bus.blue); end
        step(10'd448, 10'd10);
        checks++; if ({bus.red, bus.green, bus.blue} !== 30'h0)
            begin errors++; $display("FAIL bars_x448 got %h/%h/%h expected 000/000/000", bus.red, bus.green, bus.blue); end
    endtask

    task automatic test_manual_switch();
        step(10'd0, 10'd200);
        bus.mode_sel = 2'd2;
        step(10'd1, 10'd200);
        checks++; if (bus.pattern_id !== 2'd0) begin errors++; $display("FAIL manual_midframe got %0d expected 0", bus.pattern_id); end
        step(10'd1, 10'd479);
        checks++; if (bus.pattern_id !== 2'd0) begin errors++; $display("FAIL manual_lastline got %0d expected 0", bus.pattern_id); end
        step(10'd0, 10'd0);
        checks++; if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL manual_tick got %b expected 1", bus.frame_tick); end
        checks++; if (bus.pattern_id !== 2'd2) begin errors++; $display("FAIL manual_switch got %0d expected 2", bus.pattern_id); end
        step(10'd320, 10'd100);
        checks++; if ({bus.red, bus.green, bus.blue} !== {10'h140, 10'h0C8, 10'h000})
            begin errors++; $display("FAIL gradient got %h/%h/%h expected 140/0c8/000", bus.red, bus.green, bus.blue); end
    endtask

    task automatic test_checker();
        bus.mode_sel = 2'd1;
        frame_wrap();
        checks++; if (bus.pattern_id !== 2'd1) begin errors++; $display("FAIL checker_pid got %0d expected 1", bus.pattern_id); end
        step(10'd32, 10'd0);
        checks++; if ({bus.red, bus.green, bus.blue} !== {30{1'b1}})
            begin errors++; $display("FAIL checker_on got %h/%h/%h expected 3ff/3ff/3ff", bus.red, bus.green, bus.blue); end
        step(10'd32, 10'd32);
        checks++; if ({bus.red, bus.green, bus.blue} !== 30'h0)
            begin errors++; $display("FAIL checker_off got %h/%h/%h expected 000/000/000", bus.red, bus.green, bus.blue); end
    endtask

    task automatic test_border();
        bus.mode_sel = 2'd3;
        frame_wrap();
        checks++; if (bus.pattern_id !== 2'd3) begin errors++; $display("FAIL border_pid got %0d expected 3", bus.pattern_id); end
        step(10'd639, 10'd240);
        checks++; if (bus.blue !== 10'h3FF) begin errors++; $display("FAIL border_right got %h expected 3ff", bus.blue); end
        step(10'd320, 10'd240);
        checks++; if (bus.red !== 10'h000) begin errors++; $display("FAIL border_inner got %h expected 000", bus.red); end
        step(10'd5, 10'd479);
        checks++; if (bus.green !== 10'h3FF) begin errors++; $display("FAIL border_bottom got %h expected 3ff", bus.green); end
        step(10'd0, 10'd100);
        checks++; if (bus.red !== 10'h3FF) begin errors++; $display("FAIL border_left got %h expected 3ff", bus.red); end
    endtask

    task automatic test_auto_cycle();
        int ticks;
        logic [1:0] exp_pid;
        ticks = 0;
        do_reset();
        bus.auto = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step(10'd10, 10'd479);
            if (bus.frame_tick === 1'b1) ticks++;
            step(10'd10, 10'd0);
            if (bus.frame_tick === 1'b1) ticks++;
            exp_pid = 2'((k / 3) % 4);
            checks++; if (bus.pattern_id !== exp_pid)
                begin errors++; $display("FAIL auto_pid_tick%0d got %0d expected %0d", k, bus.pattern_id, exp_pid); end
            step(10'd11, 10'd0);
            checks++; if (bus.frame_tick !== 1'b0)
                begin errors++; $display("FAIL auto_tick_width%0d got %b expected 0", k, bus.frame_tick); end
        end
        checks++; if (ticks != 13) begin errors++; $display("FAIL auto_tick_count got %0d expected 13", ticks); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        bus.auto = 1'b1;
        frame_wrap();
        frame_wrap();
        step(10'd100, 10'd200);
        checks++; if (bus.red !== 10'h3FF) begin errors++; $display("FAIL pre_reset_red got %h expected 3ff", bus.red); end
        #2 resetn = 1'b0;
        #1;
        checks++; if ({bus.red, bus.green, bus.blue} !== 30'h0)
            begin errors++; $display("FAIL async_reset_rgb got %h/%h/%h expected 000/000/000", bus.red, bus.green, bus.blue); end
        checks++; if (bus.pattern_id !== 2'd0) begin errors++; $display("FAIL async_reset_pid got %0d expected 0", bus.pattern_id); end
        @(negedge clock);
        bus.pixel_y = '0;
        resetn = 1'b1;
        step(10'd0, 10'd0);
        checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL post_reset_no_tick got %b expected 0", bus.frame_tick); end
        step(10'd0, 10'd100);
        step(10'd0, 10'd0);
        checks++; if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL post_reset_tick got %b expected 1", bus.frame_tick); end
        checks++; if (bus.pattern_id !== 2'd0) begin errors++; $display("FAIL post_reset_count1 got %0d expected 0", bus.pattern_id); end
        frame_wrap();
        checks++; if (bus.pattern_id !== 2'd0) begin errors++; $display("FAIL post_reset_count2 got %0d expected 0", bus.pattern_id); end
        frame_wrap();
        checks++; if (bus.pattern_id !== 2'd1) begin errors++; $display("FAIL post_reset_advance got %0d expected 1", bus.pattern_id); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        resetn       = 1'b0;
        bus.auto     = 1'b0;
        bus.mode_sel = 2'd0;
        bus.pixel_x  = '0;
        bus.pixel_y  = '0;
        test_reset();
        test_bars();
        test_manual_switch();
        test_checker();
        test_border();
        test_auto_cycle();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
